// File: rtl/core_stage_sequencer.sv
// core_stage_sequencer: multi-cycle controller that walks one instruction at a
// time through fetch -> decode -> exec -> [mem] -> wb. Each stage gets a single
// enable pulse (issue cycle) and is then waited on until its done level is seen.
// The block owns the architectural PC, halts only at instruction boundaries and
// runs a per-stage watchdog.
// Optional build macro CORE_SEQ_PERF_EN adds cycle_cnt / instret counters.
module core_stage_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        fetch_en,
  input  logic        fetch_done,
  output logic        decode_en,
  input  logic        decode_done,
  input  logic        mem_skip,
  output logic        exec_en,
  input  logic        exec_done,
  input  logic [31:0] exec_pc_next,
  output logic        mem_en,
  input  logic        mem_done,
  output logic        wb_en,
  input  logic        wb_done,
  output logic        running,
  output logic        halted,
`ifdef CORE_SEQ_PERF_EN
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret,
`endif
  output logic        timeout
);

  // Watchdog width; keep at least one bit so a disabled watchdog still elaborates.
  localparam int WDW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  state_t         state, state_nxt;
  logic           issued;     // 0 in a stage's issue cycle, 1 while waiting
  logic           mskip;      // mem_skip captured at decode completion
  logic [WDW-1:0] wdog;
  logic           done_sel, in_stage, waiting, accept, expire;

  assign in_stage = (state != ST_IDLE) && (state != ST_HALT);
  assign waiting  = in_stage && issued;
  // done in the issue cycle is a stale level from the previous instruction
  assign accept   = waiting && done_sel;
  // wdog counts completed wait cycles; expiry loses to a done in the same cycle
  assign expire   = waiting && !done_sel && (TIMEOUT_CYCLES != 0) && (wdog == WD_LIM);

  // Select the completion flag of the stage currently in flight
  always_comb begin
    done_sel = 1'b0;
    case (state)
      ST_FETCH:  done_sel = fetch_done;
      ST_DECODE: done_sel = decode_done;
      ST_EXEC:   done_sel = exec_done;
      ST_MEM:    done_sel = mem_done;
      ST_WB:     done_sel = wb_done;
      default:   done_sel = 1'b0;
    endcase
  end

  // Next-state: advance on accepted done, halt at WB boundary or on watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALT: if (start) state_nxt = ST_FETCH;
      ST_FETCH:  if (accept) state_nxt = ST_DECODE;
      ST_DECODE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC:   if (accept) state_nxt = mskip ? ST_WB : ST_MEM;
      ST_MEM:    if (accept) state_nxt = ST_WB;
      ST_WB:     if (accept) state_nxt = halt_req ? ST_HALT : ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase
    if (expire) state_nxt = ST_HALT;
  end

  // State register plus issue flag, watchdog, PC, captured mem_skip and sticky timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      issued  <= 1'b0;
      wdog    <= '0;
      mskip   <= 1'b0;
      pc      <= RESET_PC;
      timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      // a fresh state always begins with its issue cycle
      issued <= in_stage && (state_nxt == state);
      if (!waiting)
        wdog <= '0;
      else if (wdog != {WDW{1'b1}})
        wdog <= wdog + WDW'(1);
      if ((state == ST_DECODE) && accept)
        mskip <= mem_skip;
      if ((state == ST_IDLE) && start)
        pc <= RESET_PC;
      else if ((state == ST_EXEC) && accept)
        pc <= exec_pc_next;
      if (expire)
        timeout <= 1'b1;
      else if ((state == ST_HALT) && start)
        timeout <= 1'b0;
    end
  end

  // Outputs: enable pulses only in the issue cycle, status from the state
  always_comb begin
    fetch_en  = (state == ST_FETCH)  && !issued;
    decode_en = (state == ST_DECODE) && !issued;
    exec_en   = (state == ST_EXEC)   && !issued;
    mem_en    = (state == ST_MEM)    && !issued;
    wb_en     = (state == ST_WB)     && !issued;
    running   = in_stage;
    halted    = (state == ST_HALT);
  end

`ifdef CORE_SEQ_PERF_EN
  // Performance counters: cycles spent running and retired instructions
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt <= 64'd0;
      instret   <= 64'd0;
    end else begin
      if (running)
        cycle_cnt <= cycle_cnt + 64'd1;
      if ((state == ST_WB) && accept)
        instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_stage_sequencer.sv
// tb_core_stage_sequencer: directed bench for core_stage_sequencer. A responder
// answers each stage one cycle after its enable; expected fetches (pc and spacing)
// are queued when an instruction is launched and popped when fetch_en appears.
module tb_core_stage_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start, halt_req;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
  logic        fetch_done, decode_done, exec_done, mem_done, wb_done, mem_skip;
  logic [31:0] pc, exec_pc_next;
  logic        running, halted, timeout;
`ifdef CORE_SEQ_PERF_EN
  logic [63:0] cycle_cnt, instret;
`endif

  core_stage_sequencer #(.RESET_PC(RPC), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req), .pc(pc),
    .fetch_en(fetch_en), .fetch_done(fetch_done),
    .decode_en(decode_en), .decode_done(decode_done), .mem_skip(mem_skip),
    .exec_en(exec_en), .exec_done(exec_done), .exec_pc_next(exec_pc_next),
    .mem_en(mem_en), .mem_done(mem_done), .wb_en(wb_en), .wb_done(wb_done),
    .running(running), .halted(halted),
`ifdef CORE_SEQ_PERF_EN
    .cycle_cnt(cycle_cnt), .instret(instret),
`endif
    .timeout(timeout)
  );

  typedef struct { logic [31:0] pc; int gap; } fexp_t;
  fexp_t sb[$];
  int    total = 0, bad = 0, cyc = 0, last_f = 0, f0 = 0;
  logic  fe_p = 1'b0, de_p = 1'b0, ee_p = 1'b0, me_p = 1'b0, we_p = 1'b0;
  logic  stale = 1'b0, mem_hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic en_of(input int w);
    case (w)
      0: return fetch_en;
      1: return decode_en;
      2: return exec_en;
      3: return mem_en;
      default: return wb_en;
    endcase
  endfunction

  // One clock: sample on the falling edge, score fetches, then drive responses.
  task automatic tick();
    fexp_t e;
    @(negedge clk);
    cyc++;
    chk("one_en", 64'($countones({fetch_en, decode_en, exec_en, mem_en, wb_en}) <= 1), 64'd1);
    if (fetch_en === 1'b1) begin
      chk("fetch_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("fetch_pc", 64'(pc), 64'(e.pc));
        if (e.gap >= 0) chk("fetch_gap", 64'(cyc - last_f), 64'(e.gap));
      end
      last_f = cyc;
    end
    fetch_done  = fe_p | (stale & fetch_en);
    decode_done = de_p;
    exec_done   = ee_p;
    if (!mem_hold) mem_done = me_p;
    wb_done     = we_p;
    fe_p = fetch_en; de_p = decode_en; ee_p = exec_en; me_p = mem_en; we_p = wb_en;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_en(input string tag, input int which, input int budget);
    int n = 0;
    while (en_of(which) !== 1'b1 && n < budget) begin tick(); n++; end
    chk(tag, 64'(en_of(which)), 64'd1);
  endtask

  task automatic run_fetch(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin tick(); n++; end
    chk("fetch_arrived", 64'(sb.size()), 64'd0);
  endtask

  task automatic launch(input logic skip, input logic [31:0] npc);
    mem_skip = skip;
    exec_pc_next = npc;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; halt_req = 1'b0; mem_skip = 1'b1;
    fetch_done = 1'b0; decode_done = 1'b0; exec_done = 1'b0; mem_done = 1'b0;
    wb_done = 1'b0; exec_pc_next = 32'h0;
    ticks(2);
    // reset state
    chk("rst_pc", 64'(pc), 64'(RPC));
    chk("rst_en", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en}), 64'd0);
    chk("rst_run", 64'({running, halted, timeout}), 64'd0);
`ifdef CORE_SEQ_PERF_EN
    chk("rst_perf", cycle_cnt | instret, 64'd0);
`endif
    rstn = 1'b1;
    ticks(2);
    chk("idle_no_fetch", 64'(fetch_en), 64'd0);

    // start: fetch_en one cycle later at RESET_PC
    sb.push_back('{pc: RPC, gap: -1});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_fetch_at_1", 64'(fetch_en), 64'd1);
    chk("t1_running", 64'(running), 64'd1);

    // branch to 0x40; next fetch carries a stale done in its issue cycle
    launch(1'b1, 32'h40); sb.push_back('{pc: 32'h40, gap: 8}); stale = 1'b1;
    run_fetch(20);
    stale = 1'b0;
    launch(1'b1, 32'h80); sb.push_back('{pc: 32'h80, gap: 8});
    run_fetch(20);
    launch(1'b0, 32'h1000); sb.push_back('{pc: 32'h1000, gap: 10});
    run_fetch(20);

    // halt requested during EXEC, taken after WB completes
    launch(1'b1, 32'h1004);
    ticks(4);
    chk("t3_exec_en", 64'(exec_en), 64'd1);
    halt_req = 1'b1;
    wait_en("t3_wb_en", 4, 10);
    ticks(2);
    chk("t3_halted", 64'({halted, running, fetch_en}), 64'b100);
    chk("t3_pc", 64'(pc), 64'h1004);
    halt_req = 1'b0;
    ticks(3);
    chk("t3_still_halted", 64'(halted), 64'd1);
    sb.push_back('{pc: 32'h1004, gap: -1});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_resume_fetch", 64'(fetch_en), 64'd1);

    // watchdog: mem never completes
    launch(1'b0, 32'h2000); mem_hold = 1'b1; mem_done = 1'b0;
    wait_en("t4_mem_en", 3, 12);
    ticks(5);
    chk("t4_not_yet", 64'({halted, timeout}), 64'd0);
    tick();
    chk("t4_expired", 64'({halted, timeout, running}), 64'b110);
    chk("t4_pc", 64'(pc), 64'h2000);
    sb.push_back('{pc: 32'h2000, gap: -1});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_resume_clear", 64'({fetch_en, timeout}), 64'b10);

    // done arriving in the expiry cycle wins
    launch(1'b0, 32'h3000);
    wait_en("t4b_mem_en", 3, 12);
    ticks(5);
    mem_done = 1'b1;
    tick();
    chk("t4b_wb_en", 64'({wb_en, timeout, halted}), 64'b100);
    mem_done = 1'b0; mem_hold = 1'b0;
    sb.push_back('{pc: 32'h3000, gap: -1});
    run_fetch(20);

    // async reset mid-DECODE
    launch(1'b1, 32'h5000);
    ticks(3);
    #2 rstn = 1'b0;
    #1;
    total++;
    chk("t5_pc", 64'(pc), 64'(RPC));
    chk("t5_outs", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en, running, halted, timeout}), 64'd0);
    total--;
    tick();
    rstn = 1'b1;
    ticks(3);
    chk("t5_idle", 64'({running, fetch_en}), 64'd0);
`ifdef CORE_SEQ_PERF_EN
    chk("t5_perf_rst", cycle_cnt | instret, 64'd0);
`endif

    // three 8-cycle instructions then halt
    sb.push_back('{pc: RPC, gap: -1});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_fetch", 64'(fetch_en), 64'd1);
    launch(1'b1, 32'h10); sb.push_back('{pc: 32'h10, gap: 8});
    run_fetch(20);
    launch(1'b1, 32'h20); sb.push_back('{pc: 32'h20, gap: 8});
    run_fetch(20);
    launch(1'b1, 32'h30); halt_req = 1'b1;
    ticks(7);
    chk("t6_running", 64'({running, halted}), 64'b10);
    tick();
    chk("t6_halted", 64'({running, halted}), 64'b01);
    chk("t6_pc", 64'(pc), 64'h30);
`ifdef CORE_SEQ_PERF_EN
    chk("t6_cycle_cnt", cycle_cnt, 64'd24);
    chk("t6_instret", instret, 64'd3);
`endif
    halt_req = 1'b0;
    ticks(3);
`ifdef CORE_SEQ_PERF_EN
    chk("t6_cycle_hold", cycle_cnt, 64'd24);
`endif
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute guard so a stuck run still ends with a report
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
